stn_name_scroller: RTL and testbench



---
 rtl/stn_pkg.sv | 65 ++++++
 rtl/stn_name_rom.sv | 41 ++++
 rtl/stn_name_scroller.sv | 146 ++++++++++++++
 tb/tb_stn_name_scroller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stn_pkg.sv
// Shared constants for the station-name display: ASCII codes, the fixed
// station name table (space-padded, MSB-first) and the scroller state encoding.
package stn_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   localparam int TBL_COUNT    = 7;
   localparam int TBL_NAME_MAX = 24;

   typedef logic [8*TBL_NAME_MAX-1:0] tbl_name_t;

   localparam tbl_name_t STN_NAME_0 = {"Nopo",                  {20{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_1 = {"Pusan Nat'l Univ",      {8{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_2 = {"Dongnae",               {17{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_3 = {"Yeonsan",               {17{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_4 = {"Seomyeon",              {16{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_5 = {"Dadaepo Beach",         {11{ASCII_SPACE}}};
   localparam tbl_name_t STN_NAME_6 = {"Seomyeon Transfer Stn", {3{ASCII_SPACE}}};

   localparam int STN_LEN_0 = 4;
   localparam int STN_LEN_1 = 16;
   localparam int STN_LEN_2 = 7;
   localparam int STN_LEN_3 = 7;
   localparam int STN_LEN_4 = 8;
   localparam int STN_LEN_5 = 13;
   localparam int STN_LEN_6 = 21;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PRESENT,
      WAIT_ACK,
      HOLD_START,
      SCROLL,
      HOLD_END
   } state_t;

   function automatic tbl_name_t tbl_name(input int unsigned i);
      case (i)
         0:       return STN_NAME_0;
         1:       return STN_NAME_1;
         2:       return STN_NAME_2;
         3:       return STN_NAME_3;
         4:       return STN_NAME_4;
         5:       return STN_NAME_5;
         6:       return STN_NAME_6;
         default: return {TBL_NAME_MAX{ASCII_SPACE}};
      endcase
   endfunction

   function automatic int tbl_len(input int unsigned i);
      case (i)
         0:       return STN_LEN_0;
         1:       return STN_LEN_1;
         2:       return STN_LEN_2;
         3:       return STN_LEN_3;
         4:       return STN_LEN_4;
         5:       return STN_LEN_5;
         6:       return STN_LEN_6;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/stn_name_rom.sv
// Combinational station name lookup: index -> space-padded name bytes, length
// and a valid flag. Unknown indices yield "?" so the display is never blank.
module stn_name_rom
   import stn_pkg::*;
#(
   parameter int NUM_STN  = 7,
   parameter int NAME_MAX = 24,
   parameter int IW       = 3,
   parameter int LW       = 5
) (
   input  logic [IW-1:0]         idx,
   output logic [8*NAME_MAX-1:0] name,
   output logic [LW-1:0]         len,
   output logic                  valid
);

   tbl_name_t tbl_entry;
   int        tbl_n;

   always_comb begin
      tbl_entry = tbl_name(32'(idx));
      tbl_n     = tbl_len(32'(idx));
      if (tbl_n > NAME_MAX) begin
         tbl_n = NAME_MAX;
      end
      name  = {NAME_MAX{ASCII_SPACE}};
      len   = LW'(1);
      valid = (32'(idx) < NUM_STN) && (32'(idx) < TBL_COUNT);
      if (valid) begin
         for (int i = 0; i < NAME_MAX; i++) begin
            if (i < TBL_NAME_MAX) begin
               name[8*(NAME_MAX-1-i) +: 8] = tbl_entry[8*(TBL_NAME_MAX-1-i) +: 8];
            end
         end
         len = LW'(tbl_n);
      end else begin
         name[8*NAME_MAX-1 -: 8] = ASCII_QMARK;
      end
   end

endmodule

// File: rtl/stn_name_scroller.sv
// Latches a station name and offers DISP_CHARS-wide windows of it to the LCD
// writer via req/ack, scrolling long names on tick with dwell at both ends.
module stn_name_scroller
   import stn_pkg::*;
#(
   parameter  int NUM_STN    = 7,
   parameter  int DISP_CHARS = 16,
   parameter  int NAME_MAX   = 24,
   parameter  int HOLD_TICKS = 3,
   localparam int IW         = (NUM_STN > 1) ? $clog2(NUM_STN) : 1,
   localparam int LW         = $clog2(NAME_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IW-1:0]           stn_idx,
   input  logic                    stn_load,
   input  logic                    tick,
   input  logic                    frame_ack,
   output logic [8*DISP_CHARS-1:0] line_ascii,
   output logic                    frame_req,
   output logic                    scrolling,
   output logic                    idx_err
);

   localparam int HW    = $clog2(HOLD_TICKS + 1);
   localparam int EXT_W = 8*(NAME_MAX + DISP_CHARS);

   state_t                state, state_nxt;
   logic [IW-1:0]         idx_q;
   logic                  load_pend;
   logic                  load_req;
   logic [8*NAME_MAX-1:0] name_q;
   logic [8*NAME_MAX-1:0] rom_name;
   logic [LW-1:0]         rom_len;
   logic                  rom_valid;
   logic [LW-1:0]         len_q;
   logic [LW-1:0]         offset, offset_nxt;
   logic [HW-1:0]         hold_cnt, hold_nxt;
   logic                  at_end;
   logic                  hold_done;
   logic [EXT_W-1:0]      win_ext;

   stn_name_rom #(
      .NUM_STN  (NUM_STN),
      .NAME_MAX (NAME_MAX),
      .IW       (IW),
      .LW       (LW)
   ) u_rom (
      .idx   (idx_q),
      .name  (rom_name),
      .len   (rom_len),
      .valid (rom_valid)
   );

   assign load_req  = stn_load | load_pend;
   assign at_end    = (32'(offset) + DISP_CHARS) == 32'(len_q);
   assign hold_done = tick && (hold_cnt == HW'(HOLD_TICKS - 1));

   // Stored names are already space-padded, so appending a window of spaces
   // and shifting by the offset yields the padded view directly.
   assign win_ext    = {name_q, {DISP_CHARS{ASCII_SPACE}}} << {offset, 3'b000};
   assign line_ascii = win_ext[EXT_W-1 -: 8*DISP_CHARS];

   always_comb begin
      state_nxt  = state;
      offset_nxt = offset;
      hold_nxt   = hold_cnt;
      case (state)
         IDLE: begin
            if (load_req) state_nxt = LOAD;
         end
         LOAD: begin
            offset_nxt = '0;
            hold_nxt   = '0;
            state_nxt  = PRESENT;
         end
         PRESENT: begin
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (frame_ack) begin
               if (load_req)        state_nxt = LOAD;
               else if (!scrolling) state_nxt = IDLE;
               else if (offset == '0) state_nxt = HOLD_START;
               else if (at_end)     state_nxt = HOLD_END;
               else                 state_nxt = SCROLL;
            end
         end
         HOLD_START, HOLD_END: begin
            if (load_req) begin
               state_nxt = LOAD;
            end else if (hold_done) begin
               hold_nxt   = '0;
               offset_nxt = (state == HOLD_START) ? LW'(1) : '0;
               state_nxt  = PRESENT;
            end else if (tick) begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         SCROLL: begin
            if (load_req) begin
               state_nxt = LOAD;
            end else if (tick) begin
               offset_nxt = offset + 1'b1;
               state_nxt  = PRESENT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A load request seen while a frame is outstanding stays pending; only the
   // most recent index is kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_q     <= '0;
         load_pend <= 1'b0;
         name_q    <= {NAME_MAX{ASCII_SPACE}};
         len_q     <= '0;
         offset    <= '0;
         hold_cnt  <= '0;
         scrolling <= 1'b0;
         idx_err   <= 1'b0;
         frame_req <= 1'b0;
      end else begin
         state     <= state_nxt;
         offset    <= offset_nxt;
         hold_cnt  <= hold_nxt;
         frame_req <= (state_nxt == PRESENT) || (state_nxt == WAIT_ACK);
         if (stn_load) begin
            idx_q     <= stn_idx;
            load_pend <= 1'b1;
         end else if (state == LOAD) begin
            load_pend <= 1'b0;
         end
         if (state == LOAD) begin
            name_q    <= rom_name;
            len_q     <= rom_len;
            scrolling <= 32'(rom_len) > DISP_CHARS;
            idx_err   <= !rom_valid;
         end
      end
   end

endmodule

// File: tb/tb_stn_name_scroller.sv
// Scoreboard bench for stn_name_scroller: a string-based reference model pushes
// expected frames as stimulus is issued; a monitor pops one per new frame_req.
module tb_stn_name_scroller;

   localparam int DISP    = 16;
   localparam int HOLD    = 3;
   localparam int NSTN    = 7;
   localparam int OP_LOAD = 0;
   localparam int OP_TICK = 1;

   logic         clk;
   logic         rst_n;
   logic [2:0]   stn_idx;
   logic         stn_load;
   logic         tick;
   logic         frame_ack;
   logic [127:0] line_ascii;
   logic         frame_req;
   logic         scrolling;
   logic         idx_err;

   typedef struct {
      logic [127:0] line;
      logic         scr;
      logic         err;
   } exp_t;

   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    ack_enable = 0;

   string stn_names[NSTN] = '{"Nopo", "Pusan Nat'l Univ", "Dongnae", "Yeonsan",
                              "Seomyeon", "Dadaepo Beach", "Seomyeon Transfer Stn"};

   string m_name = "";
   int    m_off = 0;
   int    m_cnt = 0;
   int    m_pend = -1;
   bit    m_scroll = 0;
   bit    m_err = 0;
   bit    m_waiting = 0;

   stn_name_scroller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stn_idx    (stn_idx),
      .stn_load   (stn_load),
      .tick       (tick),
      .frame_ack  (frame_ack),
      .line_ascii (line_ascii),
      .frame_req  (frame_req),
      .scrolling  (scrolling),
      .idx_err    (idx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] model_line(input string s, input int off);
      logic [127:0] ln;
      int p;
      for (int k = 0; k < DISP; k++) begin
         p = off + k;
         ln[127-8*k -: 8] = (p < s.len()) ? s[p] : 8'h20;
      end
      return ln;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic model_push();
      exp_t e;
      e.line = model_line(m_name, m_off);
      e.scr  = m_scroll;
      e.err  = m_err;
      exp_q.push_back(e);
      m_waiting = !ack_enable;
   endtask

   task automatic model_do_load(input int idx);
      if (idx < NSTN) begin
         m_name = stn_names[idx];
         m_err  = 0;
      end else begin
         m_name = "?";
         m_err  = 1;
      end
      m_off    = 0;
      m_cnt    = 0;
      m_scroll = m_name.len() > DISP;
      model_push();
   endtask

   task automatic model_load(input int idx);
      if (m_waiting) m_pend = idx;
      else           model_do_load(idx);
   endtask

   // Dwell HOLD ticks at the first and last offsets, one tick per step between.
   task automatic model_tick();
      int maxoff;
      int need;
      if (m_waiting || !m_scroll) return;
      maxoff = m_name.len() - DISP;
      need   = (m_off == 0 || m_off == maxoff) ? HOLD : 1;
      m_cnt++;
      if (m_cnt == need) begin
         m_cnt = 0;
         m_off = (m_off == maxoff) ? 0 : m_off + 1;
         model_push();
      end
   endtask

   task automatic gap();
      repeat ($urandom_range(8, 12)) @(negedge clk);
   endtask

   task automatic releaseAck();
      int p;
      ack_enable = 1;
      m_waiting  = 0;
      if (m_pend >= 0) begin
         p      = m_pend;
         m_pend = -1;
         model_do_load(p);
      end
      gap();
   endtask

   task automatic applyStimulus(input int op, input int arg);
      bit immediate;
      if (op == OP_LOAD) begin
         @(negedge clk);
         immediate = !m_waiting;
         stn_idx   = 3'(arg);
         stn_load  = 1;
         model_load(arg);
         @(negedge clk);
         stn_load = 0;
         if (immediate) checkOutput("load_req_early", 128'(frame_req), 128'(0));
         @(negedge clk);
         if (immediate) checkOutput("load_req_latency", 128'(frame_req), 128'(1));
      end else begin
         @(negedge clk);
         tick = 1;
         model_tick();
         @(negedge clk);
         tick = 0;
      end
      gap();
   endtask

   // Monitor: every rising frame_req is a new frame and must match the queue head.
   initial begin
      bit   prev;
      exp_t e;
      prev = 0;
      forever begin
         @(negedge clk);
         if (rst_n && frame_req && !prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("[TB] FAIL unexpected_frame: got line %h, required no frame", line_ascii);
            end else begin
               e = exp_q.pop_front();
               checkOutput("frame_line", line_ascii, e.line);
               checkOutput("frame_scrolling", 128'(scrolling), 128'(e.scr));
               checkOutput("frame_idx_err", 128'(idx_err), 128'(e.err));
            end
         end
         prev = frame_req;
      end
   end

   initial begin
      frame_ack = 0;
      forever begin
         @(negedge clk);
         frame_ack = rst_n && ack_enable && frame_req;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 0;
      stn_load = 0;
      tick     = 0;
      stn_idx  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_line", line_ascii, {16{8'h20}});
      checkOutput("reset_req", 128'(frame_req), 128'(0));
      checkOutput("reset_scrolling", 128'(scrolling), 128'(0));
      checkOutput("reset_idx_err", 128'(idx_err), 128'(0));
      rst_n      = 1;
      ack_enable = 1;
      repeat (2) @(negedge clk);

      $display("[TB] short name and exact-fit name");
      applyStimulus(OP_LOAD, 0);
      repeat (4) applyStimulus(OP_TICK, 0);
      applyStimulus(OP_LOAD, 1);
      repeat (4) applyStimulus(OP_TICK, 0);

      $display("[TB] long name full scroll cycle");
      applyStimulus(OP_LOAD, 6);
      repeat (13) applyStimulus(OP_TICK, 0);

      $display("[TB] slow LCD writer");
      ack_enable = 0;
      applyStimulus(OP_LOAD, 6);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (c % 5 == 0) begin
            tick = 1;
            model_tick();
         end else begin
            tick = 0;
         end
         if (c % 10 == 9) begin
            checkOutput("stall_line", line_ascii, model_line(m_name, m_off));
            checkOutput("stall_req", 128'(frame_req), 128'(1));
         end
      end
      @(negedge clk);
      tick = 0;
      releaseAck();
      repeat (5) applyStimulus(OP_TICK, 0);

      $display("[TB] loads deferred during handshake");
      ack_enable = 0;
      applyStimulus(OP_TICK, 0);
      applyStimulus(OP_LOAD, 2);
      applyStimulus(OP_LOAD, 3);
      releaseAck();

      $display("[TB] randomized loads and ticks");
      for (int r = 0; r < 10; r++) begin
         applyStimulus(OP_LOAD, $urandom_range(0, 7));
         repeat ($urandom_range(0, 14)) applyStimulus(OP_TICK, 0);
      end

      $display("[TB] invalid index and reset mid-handshake");
      applyStimulus(OP_LOAD, 7);
      ack_enable = 0;
      applyStimulus(OP_LOAD, 4);
      checkOutput("pre_reset_req", 128'(frame_req), 128'(1));
      applyStimulus(OP_LOAD, 2);
      @(negedge clk);
      rst_n     = 0;
      m_waiting = 0;
      m_pend    = -1;
      m_scroll  = 0;
      m_name    = "";
      @(negedge clk);
      checkOutput("midreset_req", 128'(frame_req), 128'(0));
      checkOutput("midreset_line", line_ascii, {16{8'h20}});
      checkOutput("midreset_scrolling", 128'(scrolling), 128'(0));
      checkOutput("midreset_idx_err", 128'(idx_err), 128'(0));
      rst_n      = 1;
      ack_enable = 1;
      repeat (15) @(negedge clk);
      applyStimulus(OP_LOAD, 5);
      repeat (3) applyStimulus(OP_TICK, 0);

      repeat (20) @(negedge clk);
      checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
